// File: rtl/exception_sequencer_pkg.sv
// Shared types for the exception sequencer: FSM states, cause codes and the
// handler vector addresses used by the exception-address mux owner.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    READ_VEC,
    WAIT_MEM,
    LOAD_PC
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'b00,
    EXC_OPCODE = 2'b01,
    EXC_OVF    = 2'b10,
    EXC_DIV0   = 2'b11
  } cause_t;

  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

  function automatic logic [7:0] vector_addr(input cause_t c);
    case (c)
      EXC_OPCODE: vector_addr = VEC_OPCODE;
      EXC_OVF:    vector_addr = VEC_OVF;
      EXC_DIV0:   vector_addr = VEC_DIV0;
      default:    vector_addr = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Exception flags in, mux select / strobes / PC vector out. The sequencer
// takes the master side; the control unit, ALU, memory and PC path the slave.
interface exception_sequencer_if;
  import exc_pkg::*;

  logic         exc_opcode;
  logic         exc_overflow;
  logic         exc_div0;
  logic [7:0]   mem_byte;
  cause_t       escolha;
  logic         epc_write;
  logic         mem_read;
  logic         pc_write;
  logic [31:0]  pc_vector;
  logic         busy;
  cause_t       cause;

  modport master (
    input  exc_opcode, exc_overflow, exc_div0, mem_byte,
    output escolha, epc_write, mem_read, pc_write, pc_vector, busy, cause
  );

  modport slave (
    output exc_opcode, exc_overflow, exc_div0, mem_byte,
    input  escolha, epc_write, mem_read, pc_write, pc_vector, busy, cause
  );

endinterface

// File: rtl/exception_sequencer_enc.sv
// Fixed-priority encoder of the raw exception flags: opcode > overflow > div0.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic   opcode,
  input  logic   overflow,
  input  logic   div0,
  output cause_t cause
);

  always_comb begin
    cause = EXC_NONE;
    if (opcode)
      cause = EXC_OPCODE;
    else if (overflow)
      cause = EXC_OVF;
    else if (div0)
      cause = EXC_DIV0;
  end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception sequencer: stalls the main FSM, saves EPC, fetches the
// handler vector byte and loads it into PC. All outputs are Moore registers.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  exception_sequencer_if.master bus
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt, wait_nxt;
  cause_t      cause_q, cause_nxt, sel_cause;
  logic [7:0]  vec_q, vec_nxt;

  exc_priority_enc u_enc (
    .opcode   (bus.exc_opcode),
    .overflow (bus.exc_overflow),
    .div0     (bus.exc_div0),
    .cause    (sel_cause)
  );

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    cause_nxt = cause_q;
    vec_nxt   = vec_q;
    case (state)
      IDLE: begin
        if (sel_cause != EXC_NONE) begin
          cause_nxt = sel_cause;
          state_nxt = SAVE_EPC;
        end
      end
      SAVE_EPC: state_nxt = READ_VEC;
      READ_VEC: begin
        wait_nxt  = WAIT_LOAD;
        state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (wait_cnt == 3'd0) begin
          vec_nxt   = bus.mem_byte;
          state_nxt = LOAD_PC;
        end else begin
          wait_nxt = wait_cnt - 3'd1;
        end
      end
      LOAD_PC:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= 3'd0;
      cause_q       <= EXC_NONE;
      vec_q         <= 8'd0;
      bus.escolha   <= EXC_NONE;
      bus.epc_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.pc_write  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      cause_q       <= cause_nxt;
      vec_q         <= vec_nxt;
      bus.escolha   <= (state_nxt != IDLE) ? cause_nxt : EXC_NONE;
      bus.epc_write <= (state_nxt == SAVE_EPC);
      bus.mem_read  <= (state_nxt == READ_VEC);
      bus.pc_write  <= (state_nxt == LOAD_PC);
      bus.busy      <= (state_nxt != IDLE);
    end
  end

  assign bus.pc_vector = {24'd0, vec_q};
  assign bus.cause     = cause_q;

endmodule
